// File: rtl/ifft_bf2_dit.sv
// Radix-2 DIT inverse butterfly: x = A + B*conj(W), y = A - B*conj(W), Q16.16, 3-stage pipeline.
// Define IFFT_STAGE_SCALE_EN for 1/2 per-stage output scaling; otherwise results saturate.
module ifft_bf2_dit #(
  localparam int unsigned DW = 32,
  localparam int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a_real,
  input  logic [DW-1:0] a_imag,
  input  logic [DW-1:0] b_real,
  input  logic [DW-1:0] b_imag,
  input  logic [DW-1:0] w_real,
  input  logic [DW-1:0] w_imag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] x_real,
  output logic [DW-1:0] x_imag,
  output logic [DW-1:0] y_real,
  output logic [DW-1:0] y_imag,
  output logic [CW-1:0] out_cnt,
  output logic          sat_flag
);

  localparam int unsigned PW   = 2 * DW;
  localparam int unsigned SW   = PW + 1;
  localparam int unsigned RW   = DW + 1;
  localparam int unsigned FRAC = 16;

  logic adv;
  logic v1, v2;
  logic signed [DW-1:0] a1_r, a1_i, b1_r, b1_i, w1_r, w1_i;
  logic signed [DW-1:0] a2_r, a2_i, t2_r, t2_i;
  logic signed [DW-1:0] t_r_c, t_i_c;
  logic [DW-1:0] xr_c, xi_c, yr_c, yi_c;
  logic ovf_xr, ovf_xi, ovf_yr, ovf_yi;
  logic sat_c;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  function automatic logic signed [PW-1:0] mul(input logic signed [DW-1:0] p,
                                               input logic signed [DW-1:0] q);
    return PW'(p) * PW'(q);
  endfunction

  // Fold a 33-bit result to 32 bits: halve when scaling, else clamp on overflow.
  function automatic logic [DW-1:0] shape(input logic signed [RW-1:0] s, output logic ovf);
    logic [DW-1:0] r;
`ifdef IFFT_STAGE_SCALE_EN
    ovf = 1'b0;
    r   = DW'(s >>> 1);
`else
    ovf = (s[DW] != s[DW-1]);
    if (!ovf)       r = s[DW-1:0];
    else if (s[DW]) r = {1'b1, {(DW-1){1'b0}}};
    else            r = {1'b0, {(DW-1){1'b1}}};
`endif
    return r;
  endfunction

  // T = B * conj(W); floor toward minus infinity via arithmetic shift of the 65-bit sum.
  always_comb begin
    t_r_c = DW'((SW'(mul(b1_r, w1_r)) + SW'(mul(b1_i, w1_i))) >>> FRAC);
    t_i_c = DW'((SW'(mul(b1_i, w1_r)) - SW'(mul(b1_r, w1_i))) >>> FRAC);
  end

  always_comb begin
    xr_c  = shape(RW'(a2_r) + RW'(t2_r), ovf_xr);
    xi_c  = shape(RW'(a2_i) + RW'(t2_i), ovf_xi);
    yr_c  = shape(RW'(a2_r) - RW'(t2_r), ovf_yr);
    yi_c  = shape(RW'(a2_i) - RW'(t2_i), ovf_yi);
    sat_c = ovf_xr | ovf_xi | ovf_yr | ovf_yi;
  end

  // Datapath stages S1/S2 carry no reset.
  always_ff @(posedge clk) begin
    if (adv) begin
      a1_r <= $signed(a_real);
      a1_i <= $signed(a_imag);
      b1_r <= $signed(b_real);
      b1_i <= $signed(b_imag);
      w1_r <= $signed(w_real);
      w1_i <= $signed(w_imag);
      a2_r <= a1_r;
      a2_i <= a1_i;
      t2_r <= t_r_c;
      t2_i <= t_i_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      x_real    <= '0;
      x_imag    <= '0;
      y_real    <= '0;
      y_imag    <= '0;
      out_cnt   <= '0;
      sat_flag  <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_cnt <= out_cnt + CW'(1);
      if (adv) begin
        v1        <= in_valid;
        v2        <= v1;
        out_valid <= v2;
        x_real    <= xr_c;
        x_imag    <= xi_c;
        y_real    <= yr_c;
        y_imag    <= yi_c;
        if (v2 && sat_c) sat_flag <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ifft_bf2_dit.md
IFFT_BF2_DIT -- requirements
Module: ifft_bf2_dit

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input butterfly operand set valid.
- in_ready  out  1  block accepts the operand set this cycle.
- a_real, a_imag  in  32  operand A, signed Q16.16.
- b_real, b_imag  in  32  operand B, signed Q16.16.
- w_real, w_imag  in  32  forward twiddle W, signed Q16.16; the block conjugates it internally.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- x_real, x_imag  out  32  A + B*conj(W), signed Q16.16.
- y_real, y_imag  out  32  A - B*conj(W), signed Q16.16.
- out_cnt  out  16  count of completed output transfers.
- sat_flag  out  1  sticky flag: some output was saturated.

Function
REQ-002 The block SHALL compute a radix-2 decimation-in-time inverse butterfly using T = B*conj(W).
- T_real = B_real*W_real + B_imag*W_imag
- T_imag = B_imag*W_real - B_real*W_imag
REQ-003 Each product SHALL be a full 64-bit signed product; each two-product sum SHALL be kept at 65 bits; T SHALL be bits [47:16] of the 65-bit sum (truncation toward minus infinity).
REQ-004 The four outputs SHALL be formed as 33-bit signed sums or differences: x = A+T and y = A-T, separately for the real and imaginary parts.
REQ-005 The block SHALL be a 3-stage pipeline:
- S1 registers the operands.
- S2 registers T together with a delayed copy of A.
- S3 registers x and y.
REQ-006 The pipeline SHALL advance when adv = !out_valid || out_ready; in_ready SHALL equal adv combinationally.
REQ-007 An input is accepted when in_valid && in_ready; on every adv cycle the valid bit SHALL shift S1 -> S2 -> S3.
- An accepted input therefore appears on out_valid 3 adv cycles later.
- With out_ready held high, latency SHALL be exactly 3 clocks.
REQ-008 While out_valid && !out_ready, all pipeline registers, outputs, out_cnt and sat_flag SHALL hold, and no input SHALL be accepted or dropped.
REQ-009 Bubbles (in_valid low on an adv cycle) SHALL propagate as invalid stages and SHALL NOT be collapsed.
REQ-010 out_cnt SHALL increment by 1 on each out_valid && out_ready cycle and wrap from 0xFFFF to 0x0000.
REQ-011 Concurrent input acceptance and output transfer in the same cycle SHALL both complete with no loss.
REQ-012 Without scaling (REQ-017), any 33-bit result outside the 32-bit range SHALL saturate: to 0x7FFFFFFF if positive, to 0x80000000 if negative.
REQ-013 sat_flag SHALL set in the cycle a saturated value is registered into S3 and stay set until reset.

Reset
REQ-014 When rst_n is low at a clock edge, the block SHALL clear:
- all stage valid bits, out_valid, sat_flag and out_cnt to 0;
- x_real, x_imag, y_real and y_imag to 0x00000000.
REQ-015 A reset asserted mid-operation SHALL discard all in-flight data with no output transfer.
- in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-016 Stage data registers other than the outputs need not be reset.

Configuration
REQ-017 The macro IFFT_STAGE_SCALE_EN SHALL select the output scaling.
- Defined: each 33-bit result is arithmetically shifted right by 1 and its low 32 bits are output (1/2 per-stage IFFT scaling). No saturation is possible, and sat_flag SHALL remain 0.
- Undefined: results are unscaled and saturated per REQ-012.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- A=1.0 (0x00010000), B=1.0, W=1.0, out_ready=1 -> 3 clocks later x_real=0x00020000, y_real=0, imaginary parts 0; with IFFT_STAGE_SCALE_EN, x_real=0x00010000.
- A=0, B=1.0, W=0+1.0j -> x_imag=0xFFFF0000, y_imag=0x00010000, real parts 0.
- A_real=0x7FFF0000, B=1.0, W=1.0, macro off -> x_real=0x7FFFFFFF and sat_flag=1 thereafter; macro on -> x_real=0x40000000 and sat_flag=0.
- 8 back-to-back inputs with out_ready low for cycles 4-8 -> in_ready low in those cycles, outputs held stable, all 8 results delivered in order, out_cnt=8.
- 3 inputs in flight, then rst_n low for 1 cycle -> out_valid=0 and out_cnt=0 next cycle, none of the 3 results ever appear.
- Preload out_cnt=0xFFFF via 65535 transfers, then 1 more transfer -> out_cnt=0x0000.
